// File: rtl/fb_pixel_writer.sv
// Frame-buffer pixel writer: queues rasterizer pixels, bounds-checks them against the
// frame buffer and commits in-range ones through a stallable word-write master.
module fb_pixel_writer #(
  parameter int DEPTH     = 16,
  parameter int FB_PIXELS = 307200
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [25:0] fb_base,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [25:0] pix_addr,
  input  logic [31:0] pix_color,
  input  logic        pix_last,
  output logic        mem_write,
  output logic [25:0] mem_address,
  output logic [31:0] mem_writedata,
  output logic [3:0]  mem_byteenable,
  input  logic        mem_waitrequest,
  output logic        tri_done,
  output logic        busy,
  input  logic        stats_clear,
  output logic [31:0] write_count,
  output logic [31:0] drop_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [25:0] FB_LIMIT   = 26'(FB_PIXELS);

  typedef enum logic {ST_EMPTY, ST_HOLD} stage_t;

  logic [58:0]   fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg, count_next;
  logic          ready_reg;
  stage_t        state_reg;
  logic          hold_last_reg, drop_pend_reg, tri_done_reg;
  logic [25:0]   addr_reg;
  logic [31:0]   data_reg;
  logic [31:0]   write_count_reg, drop_count_reg;

  logic          push, pop, write_done, fifo_empty, head_in_range, head_drop;
  logic [58:0]   head;
  logic [25:0]   head_offset;

  assign push        = pix_valid && ready_reg;
  assign fifo_empty  = (count_reg == '0);
  assign write_done  = (state_reg == ST_HOLD) && !mem_waitrequest;
  assign pop         = !fifo_empty && ((state_reg == ST_EMPTY) || write_done);
  assign count_next  = count_reg + (AW+1)'(push) - (AW+1)'(pop);

  // Head is read combinationally so a pop can load the output stage in the same cycle.
  assign head          = fifo_mem[rd_ptr_reg];
  assign head_offset   = head[57:32] - fb_base;
  assign head_in_range = (head_offset < FB_LIMIT);
  assign head_drop     = pop && !head_in_range;

  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr_reg] <= {pix_last, pix_addr, pix_color};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
      ready_reg       <= 1'b0;
      state_reg       <= ST_EMPTY;
      hold_last_reg   <= 1'b0;
      drop_pend_reg   <= 1'b0;
      tri_done_reg    <= 1'b0;
      addr_reg        <= '0;
      data_reg        <= '0;
      write_count_reg <= '0;
      drop_count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_next;
      // Ready depends only on next-cycle occupancy, so a full FIFO never accepts on a pop.
      ready_reg <= (count_next != FULL_COUNT);

      if (pop && head_in_range) begin
        state_reg     <= ST_HOLD;
        addr_reg      <= head[57:32];
        data_reg      <= head[31:0];
        hold_last_reg <= head[58];
      end else if (write_done || head_drop) begin
        state_reg <= ST_EMPTY;
      end

      drop_pend_reg <= head_drop;
      tri_done_reg  <= (write_done && hold_last_reg) || (head_drop && head[58]);

      if (stats_clear)     write_count_reg <= '0;
      else if (write_done) write_count_reg <= write_count_reg + 32'd1;

      if (stats_clear)     drop_count_reg <= '0;
      else if (head_drop)  drop_count_reg <= drop_count_reg + 32'd1;
    end
  end

  assign pix_ready      = ready_reg;
  assign mem_write      = (state_reg == ST_HOLD);
  assign mem_address    = addr_reg;
  assign mem_writedata  = data_reg;
  assign mem_byteenable = mem_write ? 4'hF : 4'h0;
  assign tri_done       = tri_done_reg;
  assign busy           = !fifo_empty || (state_reg == ST_HOLD) || drop_pend_reg;
  assign write_count    = write_count_reg;
  assign drop_count     = drop_count_reg;
endmodule
